// File: rtl/cci_pkg.sv
// rtl/cci_pkg.sv - register offsets, CTRL/STAT bit positions and IRQ order for count_compare_irq.
package cci_pkg;

  // Word index within the 32-byte window (addr[4:2]).
  localparam logic [2:0] REG_CMP0 = 3'd0;
  localparam logic [2:0] REG_CMP1 = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_SNAP = 3'd4;

  localparam int CTRL_EN0     = 0;
  localparam int CTRL_EN1     = 1;
  localparam int CTRL_IE0     = 4;
  localparam int CTRL_IE1     = 5;
  localparam int CTRL_IE_WRAP = 6;
  localparam logic [6:0] CTRL_MASK = 7'h73;

  localparam int STAT_HIT0 = 0;
  localparam int STAT_HIT1 = 1;
  localparam int STAT_WRAP = 2;

  localparam int IRQ_CMP0 = 0;
  localparam int IRQ_CMP1 = 1;
  localparam int IRQ_WRAP = 2;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/cmp_channel.sv
// rtl/cmp_channel.sv - one compare channel: CMP register, entry-edge compare, sticky hit, match pulse.
module cmp_channel
  import cci_pkg::*;
#(
  parameter int BITS = 30
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [BITS-1:0] count_i,
  input  logic [BITS-1:0] count_q_i,
  input  logic            en_i,
  input  logic            wr_i,
  input  logic [BITS-1:0] wdata_i,
  input  logic [BITS-1:0] wmask_i,
  input  logic            clr_i,
  output logic [BITS-1:0] cmp_o,
  output logic            hit_o,
  output logic            match_o
);

  logic [BITS-1:0] cmp_q, cmp_d;
  logic            hit_q, hit_d;
  logic            match_q;
  logic            evt;

  // Fires only when the count enters the compare value, so a held count hits once.
  always_comb begin
    evt   = en_i & (count_i == cmp_q) & (count_q_i != cmp_q);
    cmp_d = wr_i ? ((cmp_q & ~wmask_i) | (wdata_i & wmask_i)) : cmp_q;
    hit_d = evt | (hit_q & ~clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q   <= '0;
      hit_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      hit_q   <= hit_d;
      match_q <= evt;
    end
  end

  assign cmp_o   = cmp_q;
  assign hit_o   = hit_q;
  assign match_o = match_q;

endmodule

// File: rtl/count_compare_irq.sv
// rtl/count_compare_irq.sv - Wishbone-mapped dual compare and wrap detector on a live counter.
module count_compare_irq
  import cci_pkg::*;
#(
  parameter int          BITS      = 30,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count_i,
  output logic [1:0]      match_o,
  output logic [2:0]      user_irq
);

  logic            req, sel;
  logic            ack_q, done_q;
  logic [31:0]     dat_q, rdata;
  logic            req_we_q;
  logic [2:0]      req_off_q;
  logic [31:0]     req_dat_q, req_msk_q;
  logic [BITS-1:0] count_q, cmp0, cmp1;
  logic [6:0]      ctrl_q, ctrl_d;
  logic            wrap_q, wrap_d, wrap_evt;
  logic [2:0]      irq_q, stat, w1c;
  logic            hit0, hit1, match0, match1;
  logic            wr, wr_cmp0, wr_cmp1, wr_ctrl, wr_stat;

  // done_q holds off a second ack until the master drops stb, so a held strobe acks once.
  assign req = wbs_cyc_i & wbs_stb_i;
  assign sel = req & (wbs_adr_i[31:5] == BASE_ADDR[31:5]) & ~ack_q & ~done_q;

  assign stat = {wrap_q, hit1, hit0};

  always_comb begin
    rdata = 32'h0;
    case (wbs_adr_i[4:2])
      REG_CMP0: rdata = 32'(cmp0);
      REG_CMP1: rdata = 32'(cmp1);
      REG_CTRL: rdata = {25'h0, ctrl_q};
      REG_STAT: rdata = {29'h0, stat};
      REG_SNAP: rdata = 32'(count_q);
      default:  rdata = 32'h0;
    endcase
  end

  // Writes use the request latched at sel and commit on the ack cycle.
  always_comb begin
    wr       = ack_q & req_we_q;
    wr_cmp0  = wr & (req_off_q == REG_CMP0);
    wr_cmp1  = wr & (req_off_q == REG_CMP1);
    wr_ctrl  = wr & (req_off_q == REG_CTRL);
    wr_stat  = wr & (req_off_q == REG_STAT);
    w1c      = wr_stat ? (req_dat_q[2:0] & req_msk_q[2:0]) : 3'b000;
    ctrl_d   = wr_ctrl ? (((ctrl_q & ~req_msk_q[6:0]) | (req_dat_q[6:0] & req_msk_q[6:0])) & CTRL_MASK)
                       : ctrl_q;
    wrap_evt = (count_i < count_q);
    wrap_d   = wrap_evt | (wrap_q & ~w1c[STAT_WRAP]);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      dat_q     <= 32'h0;
      req_we_q  <= 1'b0;
      req_off_q <= 3'h0;
      req_dat_q <= 32'h0;
      req_msk_q <= 32'h0;
      count_q   <= '0;
      ctrl_q    <= 7'h0;
      wrap_q    <= 1'b0;
      irq_q     <= 3'b000;
    end else begin
      ack_q   <= sel;
      dat_q   <= sel ? rdata : 32'h0;
      done_q  <= sel | (done_q & req);
      if (sel) begin
        req_we_q  <= wbs_we_i;
        req_off_q <= wbs_adr_i[4:2];
        req_dat_q <= wbs_dat_i;
        req_msk_q <= byte_mask(wbs_sel_i);
      end
      count_q <= count_i;
      ctrl_q  <= ctrl_d;
      wrap_q  <= wrap_d;
      irq_q   <= stat & {ctrl_q[CTRL_IE_WRAP], ctrl_q[CTRL_IE1], ctrl_q[CTRL_IE0]};
    end
  end

  cmp_channel #(.BITS(BITS)) u_ch0 (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .count_i   (count_i),
    .count_q_i (count_q),
    .en_i      (ctrl_q[CTRL_EN0]),
    .wr_i      (wr_cmp0),
    .wdata_i   (req_dat_q[BITS-1:0]),
    .wmask_i   (req_msk_q[BITS-1:0]),
    .clr_i     (w1c[STAT_HIT0]),
    .cmp_o     (cmp0),
    .hit_o     (hit0),
    .match_o   (match0)
  );

  cmp_channel #(.BITS(BITS)) u_ch1 (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .count_i   (count_i),
    .count_q_i (count_q),
    .en_i      (ctrl_q[CTRL_EN1]),
    .wr_i      (wr_cmp1),
    .wdata_i   (req_dat_q[BITS-1:0]),
    .wmask_i   (req_msk_q[BITS-1:0]),
    .clr_i     (w1c[STAT_HIT1]),
    .cmp_o     (cmp1),
    .hit_o     (hit1),
    .match_o   (match1)
  );

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], req_dat_q[31:BITS], req_msk_q[31:BITS]};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign match_o   = {match1, match0};
  assign user_irq  = irq_q;

endmodule

// File: tb/tb_count_compare_irq.sv
// tb/tb_count_compare_irq.sv - directed self-checking bench for count_compare_irq.
module tb_count_compare_irq;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  bsel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [29:0] count;
  logic [1:0]  match;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_compare_irq dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (bsel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .count_i   (count),
    .match_o   (match),
    .user_irq  (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; bsel = 4'h0; dat_i = 32'h0; adr = 32'h0;
  endtask

  // wrap_commit drops count to 0 on the commit edge to collide a wrap with the W1C.
  task automatic wb_write(input string tag, input logic [7:0] off, input logic [31:0] d,
                          input logic [3:0] s, input logic wrap_commit);
    logic got;
    adr = BASE + {24'h0, off}; we = 1'b1; dat_i = d; bsel = s; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      tick();
      got = ack;
    end
    check({tag, "_ack"}, {31'h0, got}, 32'h1);
    if (wrap_commit) count = 30'h0;
    bus_idle();
    tick();
  endtask

  task automatic wb_read(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic        got;
    logic [31:0] d;
    adr = BASE + {24'h0, off}; we = 1'b0; dat_i = 32'h0; bsel = 4'hF; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    d = 32'h0;
    for (int n = 0; n < 6 && !got; n++) begin
      tick();
      got = ack;
      d = dat_o;
    end
    check({tag, "_ack"}, {31'h0, got}, 32'h1);
    check({tag, "_data"}, d, exp);
    tick();
    check({tag, "_ack_len"}, {31'h0, ack}, 32'h0);
    bus_idle();
    tick();
  endtask

  initial begin
    int nm;
    int na;
    bus_idle();
    count = 30'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset state
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_match", {30'h0, match}, 32'h0);
    check("rst_irq", {29'h0, irq}, 32'h0);
    wb_read("rst_ctrl", 8'h08, 32'h0);
    wb_read("rst_stat", 8'h0C, 32'h0);
    wb_read("rst_cmp0", 8'h00, 32'h0);

    // 2: CMP0=5, en0+ie0, ramp 0..8
    wb_write("t2_cmp0", 8'h00, 32'h5, 4'hF, 1'b0);
    wb_write("t2_ctrl", 8'h08, 32'h11, 4'hF, 1'b0);
    nm = 0;
    for (int v = 0; v <= 8; v++) begin
      count = 30'(v);
      tick();
      if (match[0]) nm++;
      if (v == 5) begin
        check("t2_match_at5", {30'h0, match}, 32'h1);
        check("t2_irq_at5", {29'h0, irq}, 32'h0);
      end
      if (v == 6) check("t2_irq_at6", {29'h0, irq}, 32'h1);
    end
    check("t2_nmatch", nm, 1);
    wb_read("t2_stat", 8'h0C, 32'h1);
    wb_read("t2_snap", 8'h10, 32'h8);

    // 3: count 8 -> 5 held (entry once, also a wrap), then W1C hit0
    nm = 0;
    count = 30'd5;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (match[0]) nm++;
    end
    check("t3_nmatch", nm, 1);
    wb_write("t3_w1c", 8'h0C, 32'h1, 4'hF, 1'b0);
    check("t3_irq_hold", {29'h0, irq}, 32'h1);
    tick();
    check("t3_irq_drop", {29'h0, irq}, 32'h0);
    wb_read("t3_stat", 8'h0C, 32'h4);

    // 4: wrap detection and set-wins against W1C
    wb_write("t4_clr", 8'h0C, 32'h7, 4'hF, 1'b0);
    wb_read("t4_stat0", 8'h0C, 32'h0);
    wb_write("t4_ctrl", 8'h08, 32'h40, 4'hF, 1'b0);
    count = 30'h3FFF_FFFF;
    tick();
    count = 30'h0;
    tick();
    check("t4_irq_lag", {29'h0, irq}, 32'h0);
    tick();
    check("t4_irq_wrap", {29'h0, irq}, 32'h4);
    wb_read("t4_stat_wrap", 8'h0C, 32'h4);
    count = 30'h3FFF_FFFF;
    tick();
    wb_write("t4_w1c_race", 8'h0C, 32'h4, 4'hF, 1'b1);
    wb_read("t4_stat_race", 8'h0C, 32'h4);
    check("t4_irq_race", {29'h0, irq}, 32'h4);

    // 5: byte lanes, unmapped offset, out-of-window
    wb_write("t5_cmp1", 8'h04, 32'hAABB_CCDD, 4'b0001, 1'b0);
    wb_read("t5_cmp1", 8'h04, 32'h0000_00DD);
    wb_read("t5_unmapped", 8'h14, 32'h0);
    adr = BASE + 32'h20; we = 1'b0; cyc = 1'b1; stb = 1'b1; bsel = 4'hF;
    na = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (ack) na++;
      if (dat_o != 32'h0) na += 10;
    end
    check("t5_outside", na, 0);
    bus_idle();
    tick();

    // equal compares fire together; clearing enables keeps hits
    wb_write("t5_clr", 8'h0C, 32'h7, 4'hF, 1'b0);
    wb_write("t5_c0", 8'h00, 32'h20, 4'hF, 1'b0);
    wb_write("t5_c1", 8'h04, 32'h20, 4'hF, 1'b0);
    wb_write("t5_en", 8'h08, 32'h03, 4'hF, 1'b0);
    count = 30'h20;
    tick();
    check("t5_both", {30'h0, match}, 32'h3);
    wb_write("t5_dis", 8'h08, 32'h00, 4'hF, 1'b0);
    wb_read("t5_hits", 8'h0C, 32'h3);

    // writing CMP equal to the live count does not fire; next entry does
    wb_write("t5_clr2", 8'h0C, 32'h7, 4'hF, 1'b0);
    wb_write("t5_en0", 8'h08, 32'h01, 4'hF, 1'b0);
    count = 30'h30;
    tick();
    wb_write("t5_c0eq", 8'h00, 32'h30, 4'hF, 1'b0);
    tick();
    check("t5_nofire", {30'h0, match}, 32'h0);
    wb_read("t5_stat_nf", 8'h0C, 32'h0);
    count = 30'h31;
    tick();
    count = 30'h30;
    tick();
    check("t5_reentry", {30'h0, match}, 32'h1);
    wb_read("t5_stat_re", 8'h0C, 32'h5);

    // 6: held strobe acks once; reset mid-transfer
    adr = BASE + 32'h08; we = 1'b0; cyc = 1'b1; stb = 1'b1; bsel = 4'hF;
    na = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (ack) na++;
    end
    check("t6_one_ack", na, 1);
    bus_idle();
    tick();
    adr = BASE; we = 1'b1; dat_i = 32'h1234; bsel = 4'hF; cyc = 1'b1; stb = 1'b1;
    rst = 1'b1;
    na = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (ack) na++;
    end
    bus_idle();
    rst = 1'b0;
    tick();
    if (ack) na++;
    check("t6_rst_noack", na, 0);
    check("t6_rst_irq", {29'h0, irq}, 32'h0);
    wb_read("t6_cmp0", 8'h00, 32'h0);
    wb_read("t6_ctrl", 8'h08, 32'h0);
    wb_read("t6_stat", 8'h0C, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
